// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one pipelined fp_mul between two requesters.
// A tag pipeline matched to the multiplier latency routes each result to its owner.
module fp_mul_arbiter #(
   parameter int FLOAT_DATA_WIDTH = 32,
   parameter int MUL_LATENCY      = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clk_en,
   input  logic                        req0_valid,
   output logic                        req0_ready,
   input  logic [FLOAT_DATA_WIDTH-1:0] req0_a,
   input  logic [FLOAT_DATA_WIDTH-1:0] req0_b,
   input  logic                        req1_valid,
   output logic                        req1_ready,
   input  logic [FLOAT_DATA_WIDTH-1:0] req1_a,
   input  logic [FLOAT_DATA_WIDTH-1:0] req1_b,
   output logic                        mul_aclr,
   output logic                        mul_clk_en,
   output logic [FLOAT_DATA_WIDTH-1:0] mul_dataa,
   output logic [FLOAT_DATA_WIDTH-1:0] mul_datab,
   input  logic [FLOAT_DATA_WIDTH-1:0] mul_result,
   output logic [FLOAT_DATA_WIDTH-1:0] res_data,
   output logic                        res0_valid,
   output logic                        res1_valid,
   output logic                        busy
);

   logic                   last_grant;
   logic                   grant0;
   logic                   grant1;
   logic                   issue;
   logic                   issue_own;
   logic [MUL_LATENCY:0]   tag_vld_p;
   logic [MUL_LATENCY:0]   tag_own_p;

   assign mul_aclr   = ~rst;
   assign mul_clk_en = clk_en;

   // Tie goes to the requester that did not win last time.
   always_comb begin
      grant0 = req0_valid && (!req1_valid || last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
   end

   assign req0_ready = clk_en & grant0;
   assign req1_ready = clk_en & grant1;
   assign issue      = req0_ready | req1_ready;
   assign issue_own  = req1_ready;

   // Issue stage feeds the multiplier; tag stage p[L] lines up with mul_result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant <= 1'b1;
         tag_vld_p  <= '0;
         tag_own_p  <= '0;
         mul_dataa  <= '0;
         mul_datab  <= '0;
         res_data   <= '0;
         res0_valid <= 1'b0;
         res1_valid <= 1'b0;
         busy       <= 1'b0;
      end else if (clk_en) begin
         tag_vld_p <= {tag_vld_p[MUL_LATENCY-1:0], issue};
         tag_own_p <= {tag_own_p[MUL_LATENCY-1:0], issue_own};
         if (issue) begin
            mul_dataa  <= issue_own ? req1_a : req0_a;
            mul_datab  <= issue_own ? req1_b : req0_b;
            last_grant <= issue_own;
         end
         res0_valid <= tag_vld_p[MUL_LATENCY] & ~tag_own_p[MUL_LATENCY];
         res1_valid <= tag_vld_p[MUL_LATENCY] &  tag_own_p[MUL_LATENCY];
         if (tag_vld_p[MUL_LATENCY])
            res_data <= mul_result;
         // After this edge the tags hold {p[L-1:0], issue} and the presented result came from p[L].
         busy <= issue | (|tag_vld_p);
      end
   end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: behavioural fp_mul stand-in, transaction-level reference
// model with a due-time queue, vector table, directed corner sequences and random traffic.
module tb_fp_mul_arbiter;

   localparam int W = 32;
   localparam int L = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         clk_en;
   logic         req0_valid, req1_valid;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         mul_aclr, mul_clk_en;
   logic [W-1:0] mul_dataa, mul_datab, mul_result;
   logic [W-1:0] res_data;
   logic         res0_valid, res1_valid, busy;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   fp_mul_arbiter #(.FLOAT_DATA_WIDTH(W), .MUL_LATENCY(L)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .mul_aclr(mul_aclr), .mul_clk_en(mul_clk_en),
      .mul_dataa(mul_dataa), .mul_datab(mul_datab), .mul_result(mul_result),
      .res_data(res_data), .res0_valid(res0_valid), .res1_valid(res1_valid), .busy(busy)
   );

   // Truncating single-precision multiply for normal operands.
   function automatic logic [31:0] sp_mul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [9:0]  e;
      logic [22:0] m;
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
      if (p[47]) begin
         m = p[46:24];
         e = e + 10'd1;
      end else begin
         m = p[45:23];
      end
      return {a[31] ^ b[31], e[7:0], m};
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [7:0] ex;
      ex = 8'(100 + $urandom_range(0, 50));
      return {1'($urandom_range(0, 1)), ex, 23'($urandom)};
   endfunction

   // Stand-in multiplier: L enabled clocks of latency, async clear.
   logic [W-1:0] mstage [0:L-1];
   always @(posedge clk or posedge mul_aclr) begin
      if (mul_aclr) begin
         for (int i = 0; i < L; i++) mstage[i] <= '0;
      end else if (mul_clk_en) begin
         mstage[0] <= sp_mul(mul_dataa, mul_datab);
         for (int i = 1; i < L; i++) mstage[i] <= mstage[i-1];
      end
   end
   assign mul_result = mstage[L-1];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
      end
   endtask

   task automatic check1(input string nm, input logic act, input logic expv);
      check(nm, {31'd0, act}, {31'd0, expv});
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Reference model: ops are queued with the enabled-edge index at which they must appear.
   typedef struct {
      logic        own;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t         q[$];
   int           en_cnt = 0;
   logic         m_lg = 1'b1;
   logic         s_rst, s_en, s_v0, s_v1, g0, g1;
   logic [31:0]  s_a0, s_b0, s_a1, s_b1;
   logic [31:0]  e_data = '0, e_da = '0, e_db = '0;
   logic         e_v0 = 1'b0, e_v1 = 1'b0, e_busy = 1'b0;

   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         s_rst = rst; s_en = clk_en; s_v0 = req0_valid; s_v1 = req1_valid;
         s_a0 = req0_a; s_b0 = req0_b; s_a1 = req1_a; s_b1 = req1_b;
         g0 = s_v0 && (!s_v1 || m_lg);
         g1 = s_v1 && (!s_v0 || !m_lg);
         if (s_rst) begin
            check1("m_ready0", req0_ready, s_en && g0);
            check1("m_ready1", req1_ready, s_en && g1);
         end
         @(posedge clk);
         #1;
         if (!rst) begin
            q.delete();
            m_lg = 1'b1;
            e_data = '0; e_da = '0; e_db = '0;
            e_v0 = 1'b0; e_v1 = 1'b0; e_busy = 1'b0;
         end else if (s_en && s_rst) begin
            en_cnt++;
            if (g0 || g1) begin
               e_da = g1 ? s_a1 : s_a0;
               e_db = g1 ? s_b1 : s_b0;
               x.own = g1;
               x.data = sp_mul(e_da, e_db);
               x.due = en_cnt + L + 1;
               q.push_back(x);
               m_lg = g1;
            end
            e_v0 = 1'b0;
            e_v1 = 1'b0;
            if (q.size() > 0 && q[0].due == en_cnt) begin
               x = q.pop_front();
               e_data = x.data;
               e_v0 = !x.own;
               e_v1 = x.own;
            end
            e_busy = e_v0 || e_v1 || (q.size() > 0);
         end
         check("m_res_data", res_data, e_data);
         check1("m_res0_valid", res0_valid, e_v0);
         check1("m_res1_valid", res1_valid, e_v1);
         check1("m_busy", busy, e_busy);
         check("m_mul_dataa", mul_dataa, e_da);
         check("m_mul_datab", mul_datab, e_db);
         check1("m_mul_aclr", mul_aclr, !rst);
         check1("m_mul_clk_en", mul_clk_en, clk_en);
      end
   end

   typedef struct {
      logic        own;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expv;
   } vec_t;

   vec_t tbl [5];

   initial begin
      logic p0, p1, h0, h1;
      tbl[0] = '{1'b0, 32'h40000000, 32'h40400000, 32'h40C00000};
      tbl[1] = '{1'b0, 32'h3F800000, 32'h3F800000, 32'h3F800000};
      tbl[2] = '{1'b1, 32'hC0000000, 32'h40800000, 32'hC1000000};
      tbl[3] = '{1'b0, 32'h3F000000, 32'h3F000000, 32'h3E800000};
      tbl[4] = '{1'b1, 32'h3FC00000, 32'h3FC00000, 32'h40100000};

      rst = 1'b0; clk_en = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      repeat (3) tick();
      rst = 1'b1;

      // Single ops from the table, each observed L+1 enabled edges after its handshake.
      for (int i = 0; i < 5; i++) begin
         if (tbl[i].own) begin
            req1_valid = 1'b1; req1_a = tbl[i].a; req1_b = tbl[i].b;
         end else begin
            req0_valid = 1'b1; req0_a = tbl[i].a; req0_b = tbl[i].b;
         end
         #1;
         check1("tbl_ready", tbl[i].own ? req1_ready : req0_ready, 1'b1);
         tick();
         req0_valid = 1'b0; req1_valid = 1'b0;
         repeat (L + 1) tick();
         check("tbl_data", res_data, tbl[i].expv);
         check1("tbl_valid", tbl[i].own ? res1_valid : res0_valid, 1'b1);
         check1("tbl_other_valid", tbl[i].own ? res0_valid : res1_valid, 1'b0);
         tick();
         check1("tbl_pulse_end", res0_valid | res1_valid, 1'b0);
      end

      // Both requesting continuously: grants alternate starting with requester 0.
      req0_valid = 1'b1; req0_a = rand_fp(); req0_b = rand_fp();
      req1_valid = 1'b1; req1_a = rand_fp(); req1_b = rand_fp();
      for (int k = 0; k < 4; k++) begin
         #1;
         check1("alt_ready0", req0_ready, (k % 2) == 0);
         check1("alt_ready1", req1_ready, (k % 2) == 1);
         tick();
         if ((k % 2) == 0) begin
            req0_a = rand_fp(); req0_b = rand_fp();
         end else begin
            req1_a = rand_fp(); req1_b = rand_fp();
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (L + 3) tick();

      // Requester 1 streaming, requester 0 joins and is served on the next cycle.
      req1_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req1_a = rand_fp(); req1_b = rand_fp();
         #1;
         check1("stream_ready1", req1_ready, 1'b1);
         tick();
      end
      req1_a = rand_fp(); req1_b = rand_fp();
      req0_valid = 1'b1; req0_a = rand_fp(); req0_b = rand_fp();
      #1;
      check1("join_ready0", req0_ready, 1'b1);
      check1("join_ready1", req1_ready, 1'b0);
      tick();
      req0_a = rand_fp(); req0_b = rand_fp();
      #1;
      check1("join_next_ready1", req1_ready, 1'b1);
      tick();
      #1;
      check1("join_next_ready0", req0_ready, 1'b1);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (L + 3) tick();

      // Three issues, freeze while the first result is presented, with a request pending.
      req0_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req0_a = rand_fp(); req0_b = rand_fp();
         tick();
      end
      req0_valid = 1'b0;
      repeat (3) tick();
      clk_en = 1'b0;
      req0_valid = 1'b1; req0_a = rand_fp(); req0_b = rand_fp();
      #1;
      check1("freeze_pulse", res0_valid, 1'b1);
      check1("freeze_ready0", req0_ready, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check1("freeze_busy", busy, 1'b1);
         check1("freeze_pulse_hold", res0_valid, 1'b1);
         check1("freeze_ready0_hold", req0_ready, 1'b0);
      end
      req0_valid = 1'b0;
      clk_en = 1'b1;
      repeat (L + 3) tick();

      // Reset while two ops are in flight.
      req0_valid = 1'b1; req0_a = rand_fp(); req0_b = rand_fp();
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = rand_fp(); req1_b = rand_fp();
      tick();
      req1_valid = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      check("rst_res_data", res_data, 32'h0);
      check("rst_mul_dataa", mul_dataa, 32'h0);
      check1("rst_valids", res0_valid | res1_valid, 1'b0);
      check1("rst_busy", busy, 1'b0);
      check1("rst_aclr", mul_aclr, 1'b1);
      tick();
      rst = 1'b1;
      repeat (L + 3) begin
         tick();
         check1("post_rst_no_pulse", res0_valid | res1_valid, 1'b0);
      end
      req0_valid = 1'b1; req0_a = rand_fp(); req0_b = rand_fp();
      req1_valid = 1'b1; req1_a = rand_fp(); req1_b = rand_fp();
      #1;
      check1("post_rst_tie0", req0_ready, 1'b1);
      check1("post_rst_tie1", req1_ready, 1'b0);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (L + 3) tick();

      // Random traffic with occasional enable drops; operands held until accepted.
      p0 = 1'b0; p1 = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!p0 && $urandom_range(0, 1) == 1) begin
            p0 = 1'b1; req0_a = rand_fp(); req0_b = rand_fp();
         end
         if (!p1 && $urandom_range(0, 1) == 1) begin
            p1 = 1'b1; req1_a = rand_fp(); req1_b = rand_fp();
         end
         req0_valid = p0;
         req1_valid = p1;
         clk_en = ($urandom_range(0, 9) != 0);
         #1;
         h0 = req0_valid && req0_ready;
         h1 = req1_valid && req1_ready;
         tick();
         if (h0) p0 = 1'b0;
         if (h1) p1 = 1'b0;
      end
      req0_valid = 1'b0; req1_valid = 1'b0; clk_en = 1'b1;
      repeat (L + 3) tick();
      check1("final_idle", busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
